halt_dump_tx: RTL

// - Result-readback path: when the CPU halts, reads data memory and the register file
//   and transmits their contents over a UART TX line, so board runs can be checked off-chip.
// - Sits beside CPU: read-only taps on memory_module data port and decode_module regs.
// - Frame: header 0xA5, MEM_WORDS words, REG_COUNT words, optional checksum byte.
// - Each word is sent high byte first.

---
 rtl/halt_dump_tx.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/halt_dump_tx.sv
// halt_dump_tx: result-readback transmitter. When the CPU halts, it reads data
// memory and the register file and sends their contents as one UART 8N1 frame:
//   0xA5, MEM_WORDS words, REG_COUNT words (each high byte first) [, checksum]
// Optional feature macro: DUMP_CHECKSUM_EN appends the XOR of every data byte
// (header excluded).
// Ports:
//   CLK       system clock
//   rst       asynchronous active-low reset
//   do_halt   CPU halt flag; a 1->0 transition arms a dump, a 0->1 clears done
//   mem_addr  data-memory read address (registered-read memory, 1 CLK latency)
//   mem_rdata data-memory read data
//   reg_addr  register-file read index
//   reg_rdata register read data (combinational from reg_addr)
//   tx        UART serial out, LSB first, idle high
//   busy      high from trigger until the last stop bit completes
//   done      high after a complete frame until re-arm or reset
`timescale 1ns/1ps
module halt_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MEM_WORDS    = 10,
  parameter int unsigned REG_COUNT    = 16,
  parameter int unsigned MEM_AW       = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              do_halt,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        reg_addr,
  input  logic [15:0]       reg_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BAUD_LAST = CLKS_PER_BIT - 1;
  localparam int unsigned MEM_LAST  = (MEM_WORDS > 0) ? MEM_WORDS - 1 : 0;
  localparam int unsigned REG_LAST  = (REG_COUNT > 0) ? REG_COUNT - 1 : 0;
  localparam logic [7:0]  HEADER_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEADER,
    S_MEM_RD,
    S_MEM_HI,
    S_MEM_LO,
    S_REG_HI,
    S_REG_LO,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;

  state_t              state;
  logic                do_halt_q;
  logic                rd_pend;
  logic [15:0]         word;
  logic                eng_active;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          bit_idx;
  logic [8:0]          shreg;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic       halt_fall_c;
  logic       halt_rise_c;
  logic       can_load_c;
  logic       load_c;
  logic [7:0] ld_byte_c;

  assign halt_fall_c = do_halt_q & ~do_halt;
  assign halt_rise_c = ~do_halt_q & do_halt;

  // Engine accepts a new byte when idle or in the last cycle of a stop bit,
  // so consecutive bytes run with no idle gap.
  always_comb begin
    can_load_c = !eng_active ||
                 ((baud_cnt == BAUD_W'(BAUD_LAST)) && (bit_idx == 4'd9));
    load_c     = 1'b0;
    ld_byte_c  = 8'h00;
    case (state)
      S_HEADER: begin load_c = can_load_c; ld_byte_c = HEADER_BYTE;      end
      S_MEM_HI: begin load_c = can_load_c; ld_byte_c = word[15:8];       end
      S_MEM_LO: begin load_c = can_load_c; ld_byte_c = word[7:0];        end
      S_REG_HI: begin load_c = can_load_c; ld_byte_c = reg_rdata[15:8];  end
      S_REG_LO: begin load_c = can_load_c; ld_byte_c = word[7:0];        end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM:   begin load_c = can_load_c; ld_byte_c = csum;             end
`endif
      default: ;
    endcase
  end

  // Byte engine: bit 0 = start, 1..8 = data LSB first, 9 = stop.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      eng_active <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= 4'd0;
      shreg      <= 9'h1FF;
      tx         <= 1'b1;
    end else if (load_c) begin
      eng_active <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= 4'd0;
      shreg      <= {1'b1, ld_byte_c};
      tx         <= 1'b0;
    end else if (eng_active) begin
      if (baud_cnt == BAUD_W'(BAUD_LAST)) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          eng_active <= 1'b0;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

  // Frame sequencer; reads for the next word overlap the byte in flight.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      do_halt_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      reg_addr  <= 4'd0;
      word      <= 16'h0000;
      rd_pend   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      do_halt_q <= do_halt;
      if (halt_rise_c) done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (halt_fall_c && !done) begin
            busy  <= 1'b1;
            state <= S_HEADER;
`ifdef DUMP_CHECKSUM_EN
            csum  <= 8'h00;
`endif
          end
        end
        S_HEADER: begin
          if (load_c) begin
            rd_pend <= 1'b0;
            state   <= (MEM_WORDS == 0) ? S_REG_HI : S_MEM_RD;
          end
        end
        // First cycle lets the registered memory see mem_addr; second latches.
        S_MEM_RD: begin
          if (!rd_pend) begin
            rd_pend <= 1'b1;
          end else begin
            word  <= mem_rdata;
            state <= S_MEM_HI;
          end
        end
        S_MEM_HI: begin
          if (load_c) begin
`ifdef DUMP_CHECKSUM_EN
            csum  <= csum ^ ld_byte_c;
`endif
            state <= S_MEM_LO;
          end
        end
        S_MEM_LO: begin
          if (load_c) begin
`ifdef DUMP_CHECKSUM_EN
            csum <= csum ^ ld_byte_c;
`endif
            if (mem_addr == MEM_AW'(MEM_LAST)) begin
              state <= S_REG_HI;
            end else begin
              mem_addr <= mem_addr + MEM_AW'(1);
              rd_pend  <= 1'b0;
              state    <= S_MEM_RD;
            end
          end
        end
        S_REG_HI: begin
          if (load_c) begin
            word  <= reg_rdata;
`ifdef DUMP_CHECKSUM_EN
            csum  <= csum ^ ld_byte_c;
`endif
            state <= S_REG_LO;
          end
        end
        S_REG_LO: begin
          if (load_c) begin
`ifdef DUMP_CHECKSUM_EN
            csum <= csum ^ ld_byte_c;
`endif
            if (reg_addr == 4'(REG_LAST)) begin
`ifdef DUMP_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_FIN;
`endif
            end else begin
              reg_addr <= reg_addr + 4'd1;
              state    <= S_REG_HI;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (load_c) state <= S_FIN;
        end
`endif
        // Frame ends exactly when the last stop bit completes.
        S_FIN: begin
          if (can_load_c) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_addr <= '0;
            reg_addr <= 4'd0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
